// File: rtl/cpu_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per clock, results held until the next completion.
// Optional build macro CPU_DIV_EARLY_OUT_EN: divide-by-zero and |dividend|<|divisor| skip the iteration phase.
module cpu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rawDividend_q, rawDividend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             negQ_q, negQ_d;
  logic             negR_q, negR_d;
  logic             divZero_q, divZero_d;
  logic             done_q, done_d;

  logic             dividendNeg, divisorNeg;
  logic [WIDTH-1:0] absDividend, absDivisor;
  logic [WIDTH:0]   accShift;
  logic             trialFits;
  logic [WIDTH-1:0] trialDiff;

  assign dividendNeg = signed_i & dividend_i[WIDTH-1];
  assign divisorNeg  = signed_i & divisor_i[WIDTH-1];
  assign absDividend = dividendNeg ? -dividend_i : dividend_i;
  assign absDivisor  = divisorNeg  ? -divisor_i  : divisor_i;

  // Shifted partial remainder needs one extra bit; a successful trial always fits back into WIDTH bits.
  assign accShift  = {acc_q, quo_q[WIDTH-1]};
  assign trialFits = accShift >= {1'b0, div_q};
  assign trialDiff = accShift[WIDTH-1:0] - div_q;

`ifdef CPU_DIV_EARLY_OUT_EN
  logic earlyOut;
  assign earlyOut = (divisor_i == '0) || (absDividend < absDivisor);
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    acc_d         = acc_q;
    quo_d         = quo_q;
    div_d         = div_q;
    rawDividend_d = rawDividend_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    negQ_d        = negQ_q;
    negR_d        = negR_q;
    divZero_d     = divZero_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d       = RUN;
          count_d       = '0;
          acc_d         = '0;
          quo_d         = absDividend;
          div_d         = absDivisor;
          rawDividend_d = dividend_i;
          negQ_d        = dividendNeg ^ divisorNeg;
          negR_d        = dividendNeg;
          divZero_d     = (divisor_i == '0);
`ifdef CPU_DIV_EARLY_OUT_EN
          // Quotient is trivially zero and the remainder is the dividend magnitude.
          if (earlyOut) begin
            state_d = FIX;
            acc_d   = absDividend;
            quo_d   = '0;
          end
`endif
        end
      end
      RUN: begin
        acc_d   = trialFits ? trialDiff : accShift[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], trialFits};
        count_d = count_q + 1'b1;
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (divZero_q) begin
          quotient_d  = '1;
          remainder_d = rawDividend_q;
        end else begin
          quotient_d  = negQ_q ? -quo_q : quo_q;
          remainder_d = negR_q ? -acc_q : acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      acc_q         <= '0;
      quo_q         <= '0;
      div_q         <= '0;
      rawDividend_q <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      negQ_q        <= 1'b0;
      negR_q        <= 1'b0;
      divZero_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      acc_q         <= acc_d;
      quo_q         <= quo_d;
      div_q         <= div_d;
      rawDividend_q <= rawDividend_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      negQ_q        <= negQ_d;
      negR_q        <= negR_d;
      divZero_q     <= divZero_d;
      done_q        <= done_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_cpu_divider.sv
// Directed testbench for cpu_divider: table of hand-computed vectors plus
// sequences for back-to-back starts, ignored mid-op starts and reset abort.
module tb_cpu_divider;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;

  int checkCount = 0;
  int passCount  = 0;

`ifdef CPU_DIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[14];

  cpu_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record one comparison; mismatches print a single FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int expLatency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa;
    logic [31:0] bb;
    aa = (sgn && a[31]) ? -a : a;
    bb = (sgn && b[31]) ? -b : b;
    if (EarlyOut && ((b == 32'd0) || (aa < bb))) return 1;
    return 33;
  endfunction

  // Issue one operation, then count clocks until done_o (bounded).
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int busyCnt);
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    lat        = 0;
    busyCnt    = 0;
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    dividend_i = $urandom;
    divisor_i  = $urandom;
    if (busy_o) busyCnt++;
    while (!done_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy_o) busyCnt++;
    end
  endtask

  initial begin
    int lat;
    int busyCnt;
    int holdErr;
    int doneSeen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[5]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234};
    vecs[6]  = '{1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vecs[8]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1};
    vecs[9]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5};
    vecs[10] = '{1'b1, 32'hFFFF_FFFB,  32'd9,          32'd0,          32'hFFFF_FFFB};
    vecs[11] = '{1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C};
    vecs[12] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[13] = '{1'b0, 32'hDEAD_BEEF,  32'h0000_0010,  32'h0DEA_DBEE,  32'h0000_000F};

    rst_n      = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset done", {31'd0, done_o}, 32'd0);
    checkOutput("reset quotient", quotient_o, 32'd0);
    checkOutput("reset remainder", remainder_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busyCnt);
      checkOutput($sformatf("vec%0d latency", i), lat, expLatency(vecs[i].sgn, vecs[i].a, vecs[i].b));
      checkOutput($sformatf("vec%0d busy cycles", i), busyCnt, expLatency(vecs[i].sgn, vecs[i].a, vecs[i].b));
      checkOutput($sformatf("vec%0d quotient", i), quotient_o, vecs[i].q);
      checkOutput($sformatf("vec%0d remainder", i), remainder_o, vecs[i].r);
    end

    // start_i held high with new operands mid-op is ignored; on the done cycle it is accepted.
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    @(posedge clk);
    #1;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    lat = 0;
    while (!done_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("held start first latency", lat, 33);
    checkOutput("held start first quotient", quotient_o, 32'd14);
    checkOutput("held start first remainder", remainder_o, 32'd2);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    checkOutput("done pulse width", {31'd0, done_o}, 32'd0);
    checkOutput("back-to-back busy", {31'd0, busy_o}, 32'd1);
    lat = 0;
    holdErr = 0;
    while (!done_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done_o && (quotient_o !== 32'd14 || remainder_o !== 32'd2)) holdErr++;
    end
    checkOutput("back-to-back latency", lat, 33);
    checkOutput("back-to-back quotient", quotient_o, 32'd333);
    checkOutput("back-to-back remainder", remainder_o, 32'd1);
    checkOutput("results held between pulses", holdErr, 0);

    // Asynchronous reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'hDEAD_BEEF;
    divisor_i  = 32'h0000_0010;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy_o}, 32'd0);
    checkOutput("abort done", {31'd0, done_o}, 32'd0);
    checkOutput("abort quotient", quotient_o, 32'd0);
    checkOutput("abort remainder", remainder_o, 32'd0);
    doneSeen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done_o) doneSeen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done_o) doneSeen++;
    end
    checkOutput("no done after abort", doneSeen, 0);
    applyStimulus(1'b0, 32'd100, 32'd7, lat, busyCnt);
    checkOutput("post-abort latency", lat, 33);
    checkOutput("post-abort quotient", quotient_o, 32'd14);
    checkOutput("post-abort remainder", remainder_o, 32'd2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
